lsu_mem_access: RTL and testbench

- Parametrised load/store access unit between the MEM pipeline stage and the data-memory port.
- For stores: accepts one request per transaction, checks alignment, and generates byte enables and a lane-replicated write-data bus.
- For loads: waits a variable number of cycles for the memory acknowledge, then extracts and zero- or sign-extends the addressed byte, half or word.
- Generalises the combinational load extender to DW = 32/64 and adds stores, alignment exceptions and a multi-cycle handshake.

---
 rtl/lsu_mem_access_pkg.sv | 42 ++++
 rtl/lsu_mem_access_if.sv | 40 ++++
 rtl/lsu_mem_access_load_ext.sv | 32 +++
 rtl/lsu_mem_access.sv | 124 ++++++++++++
 tb/tb_lsu_mem_access.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_access_pkg.sv
// Shared types for the load/store access unit: op codes, exceptions, FSM states.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_FULL = 3'b000,
    OP_BU   = 3'b001,
    OP_B    = 3'b010,
    OP_HU   = 3'b011,
    OP_H    = 3'b100,
    OP_WU   = 3'b101,
    OP_W    = 3'b110,
    OP_RSVD = 3'b111
  } lsu_op_e;

  typedef enum logic [1:0] {
    EXC_NONE = 2'b00,
    EXC_ADEL = 2'b01,
    EXC_ADES = 2'b10
  } lsu_exc_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } lsu_state_e;

  // log2 of the access size in bytes; full and reserved map to the bus width,
  // and a word on a 32-bit bus is simply a full access.
  function automatic logic [2:0] op_lg_size(input logic [2:0] op, input int unsigned lg_nb);
    case (op)
      OP_BU, OP_B: return 3'd0;
      OP_HU, OP_H: return 3'd1;
      OP_WU, OP_W: return (lg_nb > 2) ? 3'd2 : 3'(lg_nb);
      default:     return 3'(lg_nb);
    endcase
  endfunction

  function automatic logic op_signed(input logic [2:0] op);
    return (op == OP_B) || (op == OP_H) || (op == OP_W);
  endfunction

endpackage

// File: rtl/lsu_mem_access_if.sv
// Pipeline request/response and data-memory port bundle.
interface lsu_mem_access_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  localparam int NB = DW / 8;

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [NB-1:0] mem_be;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_exc;

  // Access unit side
  modport slave (
    input  req_valid, req_we, req_op, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           rsp_valid, rsp_rdata, rsp_exc
  );

  // Pipeline + memory side
  modport master (
    output req_valid, req_we, req_op, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           rsp_valid, rsp_rdata, rsp_exc
  );
endinterface

// File: rtl/lsu_mem_access_load_ext.sv
// Combinational lane extractor: picks the addressed byte/half/word out of the
// aligned memory word and zero- or sign-extends it to DW bits.
module lsu_load_ext
  import lsu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [$clog2(DW/8)-1:0] off_i,
  input  logic [2:0]              op_i,
  input  logic [DW-1:0]           rdata_i,
  output logic [DW-1:0]           data_o
);
  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);
  localparam int IW = $clog2(DW);

  logic [2:0]    lg;
  logic [DW-1:0] lane;
  logic [DW-1:0] mask;
  logic [IW-1:0] msb_idx;
  logic          sgn;

  // Shift the lane down to bit 0, mask to its size, then fill the upper bits.
  always_comb begin
    lg      = op_lg_size(op_i, OW);
    lane    = rdata_i >> {off_i, 3'b000};
    mask    = ~({DW{1'b1}} << (32'd8 << lg));
    msb_idx = IW'((32'd8 << lg) - 32'd1);
    sgn     = op_signed(op_i) & lane[msb_idx];
    data_o  = (lane & mask) | (sgn ? ~mask : '0);
  end
endmodule

// File: rtl/lsu_mem_access.sv
// Load/store access unit between the MEM stage and the data-memory port.
// One transaction at a time: IDLE accepts, WAIT holds the memory request
// until ack, RESP pulses the response for one cycle.
module lsu_mem_access
  import lsu_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int NB = DW / 8
) (
  input logic              clk,
  input logic              reset,
  lsu_mem_access_if.slave  bus
);
  localparam int OW = $clog2(NB);

  lsu_state_e    state_q;
  logic          we_q;
  logic [2:0]    op_q;
  logic [OW-1:0] off_q;
  logic          mem_req_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [NB-1:0] mem_be_q;
  logic [DW-1:0] mem_wdata_q;
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_rdata_q;
  logic [1:0]    rsp_exc_q;

  logic [2:0]    req_lg;
  logic          req_mis_d;
  logic [NB-1:0] be_d;
  logic [DW-1:0] wdata_d;
  logic [DW-1:0] ld_data_d;
  int            lane_mask;

  // Decode the incoming request: alignment, byte enables and replicated data.
  // Loads leave be/wdata at zero so the memory sees no write lanes.
  always_comb begin
    req_lg    = op_lg_size(bus.req_op, OW);
    lane_mask = (32'd1 << req_lg) - 32'd1;
    req_mis_d = |(bus.req_addr[OW-1:0] & OW'(lane_mask));
    be_d      = '0;
    wdata_d   = '0;
    if (bus.req_we) begin
      be_d = NB'((32'd1 << (32'd1 << req_lg)) - 32'd1) << bus.req_addr[OW-1:0];
      for (int i = 0; i < NB; i++)
        wdata_d[i*8 +: 8] = bus.req_wdata[(i & lane_mask)*8 +: 8];
    end
  end

  lsu_load_ext #(.DW(DW)) u_load_ext (
    .off_i   (off_q),
    .op_i    (op_q),
    .rdata_i (bus.mem_rdata),
    .data_o  (ld_data_d)
  );

  // Transaction FSM; every memory and response output is a register here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      op_q        <= '0;
      off_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_exc_q   <= EXC_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            we_q  <= bus.req_we;
            op_q  <= bus.req_op;
            off_q <= bus.req_addr[OW-1:0];
            if (req_mis_d) begin
              // Misaligned: skip memory entirely and report the exception.
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
              rsp_exc_q   <= bus.req_we ? EXC_ADES : EXC_ADEL;
              state_q     <= ST_RESP;
            end else begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.req_we;
              mem_addr_q  <= {bus.req_addr[AW-1:OW], OW'(0)};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
              state_q     <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (bus.mem_ack) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= we_q ? '0 : ld_data_d;
            rsp_exc_q   <= EXC_NONE;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          rsp_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_exc   = rsp_exc_q;
endmodule

// File: tb/tb_lsu_mem_access.sv
// Scoreboard bench: stimulus pushes expected responses/memory transactions,
// independent monitor and memory-responder processes pop and compare.
module tb_lsu_mem_access;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_mem_access_if #(.DW(32), .AW(32)) ifa ();
  lsu_mem_access_if #(.DW(64), .AW(32)) ifb ();

  lsu_mem_access #(.DW(32), .AW(32)) dut_a (.clk(clk), .reset(rst), .bus(ifa));
  lsu_mem_access #(.DW(64), .AW(32)) dut_b (.clk(clk), .reset(rst), .bus(ifb));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ncmp = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] rdata;
    logic [1:0]  exc;
    int          acc;
    int          lat;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    int          dly;
    logic [63:0] rdata;
  } mem_t;

  rsp_t rq_a[$];
  rsp_t rq_b[$];
  mem_t mq_a[$];
  bit   manual_a = 1'b0;

  // Response monitors: every rsp_valid must match the oldest expectation.
  always @(negedge clk) begin
    rsp_t e;
    if (ifa.rsp_valid) begin
      if (rq_a.size() == 0) check("a_spurious_rsp", 64'd1, 64'd0);
      else begin
        e = rq_a.pop_front();
        check("a_rdata", 64'(ifa.rsp_rdata), e.rdata);
        check("a_exc", 64'(ifa.rsp_exc), 64'(e.exc));
        check("a_lat", 64'(cyc - e.acc + 1), 64'(e.lat));
      end
    end
  end

  always @(negedge clk) begin
    rsp_t e;
    if (ifb.rsp_valid) begin
      if (rq_b.size() == 0) check("b_spurious_rsp", 64'd1, 64'd0);
      else begin
        e = rq_b.pop_front();
        check("b_rdata", ifb.rsp_rdata, e.rdata);
        check("b_exc", 64'(ifb.rsp_exc), 64'(e.exc));
        check("b_lat", 64'(cyc - e.acc + 1), 64'(e.lat));
      end
    end
  end

  // Memory model for the 32-bit unit: checks the request, holds it for dly
  // cycles checking stability, then acks with the scripted read data.
  initial begin
    mem_t        m;
    logic [63:0] s_ctl, s_dat;
    ifa.mem_ack   = 1'b0;
    ifa.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!manual_a && ifa.mem_req) begin
        if (mq_a.size() == 0) begin
          check("a_spurious_memreq", 64'd1, 64'd0);
          m = '{we: 1'b0, addr: '0, be: '0, wdata: '0, dly: 0, rdata: '0};
        end else begin
          m = mq_a.pop_front();
          check("a_mem_we", 64'(ifa.mem_we), 64'(m.we));
          check("a_mem_addr", 64'(ifa.mem_addr), 64'(m.addr));
          check("a_mem_be", 64'(ifa.mem_be), 64'(m.be[3:0]));
          check("a_mem_wdata", 64'(ifa.mem_wdata), m.wdata);
        end
        s_ctl = {58'd0, ifa.mem_req, ifa.mem_we, ifa.mem_be};
        s_dat = {ifa.mem_addr, ifa.mem_wdata};
        repeat (m.dly) begin
          @(negedge clk);
          check("a_wait_stable_ctl", {58'd0, ifa.mem_req, ifa.mem_we, ifa.mem_be}, s_ctl);
          check("a_wait_stable_dat", {ifa.mem_addr, ifa.mem_wdata}, s_dat);
        end
        ifa.mem_rdata = m.rdata[31:0];
        ifa.mem_ack   = 1'b1;
        @(negedge clk);
        ifa.mem_ack   = 1'b0;
        ifa.mem_rdata = '0;
        check("a_memreq_drop", 64'(ifa.mem_req), 64'd0);
      end
    end
  end

  // Present a request on the 32-bit unit (called at a negedge); queue the
  // expectations just before the accepting edge.
  task automatic issue_a(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic [1:0] exp_exc, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input int dly,
                         input logic [31:0] rdata, input bit hold, input bit track);
    int n = 0;
    ifa.req_valid = 1'b1;
    ifa.req_we    = we;
    ifa.req_op    = op;
    ifa.req_addr  = addr;
    ifa.req_wdata = wdata;
    while (!ifa.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ifa.req_ready) begin
      check("a_accept_timeout", 64'd0, 64'd1);
      ifa.req_valid = 1'b0;
      return;
    end
    if (track) begin
      rq_a.push_back('{rdata: 64'(exp_rdata), exc: exp_exc, acc: cyc + 1,
                       lat: (exp_exc != EXC_NONE) ? 1 : 2 + dly});
      if (exp_exc == EXC_NONE)
        mq_a.push_back('{we: we, addr: addr & 32'hFFFF_FFFC, be: 8'(exp_be),
                         wdata: 64'(exp_wdata), dly: dly, rdata: 64'(rdata)});
    end
    @(negedge clk);
    if (!hold) ifa.req_valid = 1'b0;
  endtask

  // Present a request on the 64-bit unit and answer memory immediately.
  task automatic issue_b(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [63:0] wdata, input logic [63:0] exp_rdata,
                         input logic [1:0] exp_exc, input logic [7:0] exp_be,
                         input logic [63:0] exp_wdata, input logic [63:0] rdata);
    int n = 0;
    ifb.req_valid = 1'b1;
    ifb.req_we    = we;
    ifb.req_op    = op;
    ifb.req_addr  = addr;
    ifb.req_wdata = wdata;
    while (!ifb.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ifb.req_ready) begin
      check("b_accept_timeout", 64'd0, 64'd1);
      ifb.req_valid = 1'b0;
      return;
    end
    rq_b.push_back('{rdata: exp_rdata, exc: exp_exc, acc: cyc + 1,
                     lat: (exp_exc != EXC_NONE) ? 1 : 2});
    @(negedge clk);
    ifb.req_valid = 1'b0;
    if (exp_exc == EXC_NONE) begin
      check("b_mem_req", 64'(ifb.mem_req), 64'd1);
      check("b_mem_we", 64'(ifb.mem_we), 64'(we));
      check("b_mem_addr", 64'(ifb.mem_addr), 64'(addr & 32'hFFFF_FFF8));
      check("b_mem_be", 64'(ifb.mem_be), 64'(exp_be));
      check("b_mem_wdata", ifb.mem_wdata, exp_wdata);
      ifb.mem_rdata = rdata;
      ifb.mem_ack   = 1'b1;
      @(negedge clk);
      ifb.mem_ack   = 1'b0;
    end else begin
      check("b_no_memreq", 64'(ifb.mem_req), 64'd0);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((rq_a.size() != 0 || rq_b.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  initial begin
    ifa.req_valid = 1'b0; ifa.req_we = 1'b0; ifa.req_op = '0; ifa.req_addr = '0; ifa.req_wdata = '0;
    ifb.req_valid = 1'b0; ifb.req_we = 1'b0; ifb.req_op = '0; ifb.req_addr = '0; ifb.req_wdata = '0;
    ifb.mem_ack = 1'b0; ifb.mem_rdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_req_ready", 64'(ifa.req_ready), 64'd1);
    check("rst_mem_req", 64'(ifa.mem_req), 64'd0);
    check("rst_mem_we", 64'(ifa.mem_we), 64'd0);
    check("rst_mem_addr", 64'(ifa.mem_addr), 64'd0);
    check("rst_mem_be", 64'(ifa.mem_be), 64'd0);
    check("rst_mem_wdata", 64'(ifa.mem_wdata), 64'd0);
    check("rst_rsp_valid", 64'(ifa.rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(ifa.rsp_rdata), 64'd0);
    check("rst_rsp_exc", 64'(ifa.rsp_exc), 64'd0);
    check("rst_b_ready", 64'(ifb.req_ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // 32-bit directed vectors: we op addr wdata | rdata exc be wdata | dly memdata
    issue_a(0, 3'b010, 32'h1003, 0,            32'hFFFF_FF80, 2'b00, 4'b0000, 32'h0,         2, 32'h80FF_1234, 0, 1);
    drain();
    issue_a(1, 3'b011, 32'h2002, 32'h1234_ABCD, 32'h0,        2'b00, 4'b1100, 32'hABCD_ABCD, 0, 32'h0,         0, 1);
    drain();
    issue_a(0, 3'b100, 32'h0001, 0,            32'h0,         2'b01, 4'b0000, 32'h0,         0, 32'h0,         0, 1);
    drain();
    issue_a(1, 3'b100, 32'h0001, 32'hFFFF,     32'h0,         2'b10, 4'b0000, 32'h0,         0, 32'h0,         0, 1);
    drain();
    issue_a(0, 3'b001, 32'h1002, 0,            32'h0000_00FF, 2'b00, 4'b0000, 32'h0,         1, 32'h80FF_1234, 0, 1);
    issue_a(0, 3'b011, 32'h0002, 0,            32'h0000_80FF, 2'b00, 4'b0000, 32'h0,         0, 32'h80FF_1234, 0, 1);
    issue_a(0, 3'b100, 32'h0002, 0,            32'hFFFF_80FF, 2'b00, 4'b0000, 32'h0,         3, 32'h80FF_1234, 0, 1);
    issue_a(0, 3'b000, 32'h0010, 0,            32'hDEAD_BEEF, 2'b00, 4'b0000, 32'h0,         0, 32'hDEAD_BEEF, 0, 1);
    issue_a(0, 3'b111, 32'h0014, 0,            32'hCAFE_F00D, 2'b00, 4'b0000, 32'h0,         0, 32'hCAFE_F00D, 0, 1);
    issue_a(0, 3'b110, 32'h0008, 0,            32'h8000_0000, 2'b00, 4'b0000, 32'h0,         0, 32'h8000_0000, 0, 1);
    issue_a(1, 3'b000, 32'h0002, 32'h1,        32'h0,         2'b10, 4'b0000, 32'h0,         0, 32'h0,         0, 1);
    issue_a(0, 3'b101, 32'h0002, 0,            32'h0,         2'b01, 4'b0000, 32'h0,         0, 32'h0,         0, 1);
    issue_a(1, 3'b101, 32'h0004, 32'hA5A5_0F0F, 32'h0,        2'b00, 4'b1111, 32'hA5A5_0F0F, 1, 32'h0,         0, 1);
    drain();

    // req_valid held high across three back-to-back requests
    issue_a(0, 3'b001, 32'h1002, 0,            32'h0000_00FF, 2'b00, 4'b0000, 32'h0,         1, 32'h80FF_1234, 1, 1);
    issue_a(1, 3'b001, 32'h0003, 32'h1234_56EF, 32'h0,        2'b00, 4'b1000, 32'hEFEF_EFEF, 0, 32'h0,         1, 1);
    issue_a(0, 3'b100, 32'h0003, 0,            32'h0,         2'b01, 4'b0000, 32'h0,         0, 32'h0,         0, 1);
    drain();

    // Reset in WAIT; ack afterwards must be ignored
    manual_a = 1'b1;
    issue_a(0, 3'b000, 32'h0040, 0, 32'h0, 2'b00, 4'b0000, 32'h0, 0, 32'h0, 0, 0);
    check("rstw_memreq_before", 64'(ifa.mem_req), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstw_ready", 64'(ifa.req_ready), 64'd1);
    check("rstw_memreq", 64'(ifa.mem_req), 64'd0);
    @(negedge clk);
    ifa.mem_rdata = 32'h1111_2222;
    ifa.mem_ack   = 1'b1;
    @(negedge clk);
    ifa.mem_ack   = 1'b0;
    check("rstw_ready_after_ack", 64'(ifa.req_ready), 64'd1);
    check("rstw_no_rsp", 64'(ifa.rsp_valid), 64'd0);
    @(negedge clk);
    check("rstw_no_rsp2", 64'(ifa.rsp_valid), 64'd0);
    manual_a = 1'b0;
    issue_a(0, 3'b011, 32'h0042, 0, 32'h0000_5678, 2'b00, 4'b0000, 32'h0, 0, 32'h5678_9ABC, 0, 1);
    drain();

    // 64-bit unit
    issue_b(0, 3'b110, 32'h000C, 64'h0, 64'hFFFF_FFFF_8000_0001, 2'b00, 8'h00, 64'h0, 64'h8000_0001_0000_0000);
    issue_b(0, 3'b101, 32'h000C, 64'h0, 64'h0000_0000_8000_0001, 2'b00, 8'h00, 64'h0, 64'h8000_0001_0000_0000);
    issue_b(0, 3'b100, 32'h0006, 64'h0, 64'hFFFF_FFFF_FFFF_8000, 2'b00, 8'h00, 64'h0, 64'h8000_0001_0000_0000);
    issue_b(1, 3'b101, 32'h0004, 64'h1122_3344_5566_7788, 64'h0, 2'b00, 8'hF0, 64'h5566_7788_5566_7788, 64'h0);
    issue_b(1, 3'b001, 32'h0007, 64'h1122_3344_5566_7788, 64'h0, 2'b00, 8'h80, 64'h8888_8888_8888_8888, 64'h0);
    issue_b(0, 3'b000, 32'h0004, 64'h0, 64'h0, 2'b01, 8'h00, 64'h0, 64'h0);
    drain();

    check("a_leftover_rsp", 64'(rq_a.size()), 64'd0);
    check("a_leftover_mem", 64'(mq_a.size()), 64'd0);
    check("b_leftover_rsp", 64'(rq_b.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end
endmodule
